// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csa_pkg
// Brief    : Shared encodings, state type and sizing helpers for the
//            carry-save modular accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package csa_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_CORRECT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Two guard bits give room for subtraction sign and a 2Q overshoot.
    function automatic int calc_iw(input int width);
        return width + 2;
    endfunction

    function automatic int calc_nch(input int width, input int chunk);
        return (calc_iw(width) + chunk - 1) / chunk;
    endfunction

    localparam logic [254:0] Q25519 = '1 - 255'd18;

endpackage : csa_pkg
`default_nettype wire

// File: rtl/csa_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : csa_chunk_adder
// Brief    : CHUNK-bit ripple/carry-propagate adder slice with carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
module csa_chunk_adder #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule : csa_chunk_adder
`default_nettype wire

// File: rtl/csa_mod_accum.sv
`default_nettype none
// ============================================================================
// Module   : csa_mod_accum
// Brief    : Multi-operand carry-save accumulator with chunked resolve and a
//            single conditional modular correction.
// Revision : 1.0 - initial release
// ============================================================================
module csa_mod_accum
    import csa_pkg::*;
#(
    parameter int WIDTH = 255,
    parameter int CHUNK = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_resolve,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);

    localparam int IW  = calc_iw(WIDTH);
    localparam int NCH = calc_nch(WIDTH, CHUNK);
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    s_q, s_d;
    logic [IW-1:0]    c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    // ------------------------------------------------------------------
    // Carry-save row: one full adder deep, carry shifted left by one.
    // ------------------------------------------------------------------
    logic [IW-1:0] w_x;
    logic [IW-1:0] w_sum;
    logic [IW-1:0] w_cry_sh;

    assign w_x = (i_op == OP_ADD) ?  {{(IW-WIDTH){1'b0}}, i_a}
                                  : ~{{(IW-WIDTH){1'b0}}, i_a};

    // Bit 0 of the shifted carry is always free, so it carries the +1 of negation.
    assign w_cry_sh[0] = (i_op == OP_SUB);

    for (genvar i = 0; i < IW; i++) begin : g_csa
        assign w_sum[i] = s_q[i] ^ c_q[i] ^ w_x[i];
        if (i < IW - 1) begin : g_cry
            assign w_cry_sh[i+1] = (s_q[i] & c_q[i]) | (s_q[i] & w_x[i]) | (c_q[i] & w_x[i]);
        end
    end

    // ------------------------------------------------------------------
    // Chunked carry-propagate path shared by RESOLVE and CORRECT.
    // ------------------------------------------------------------------
    logic [IW-1:0]    w_qx;
    logic             w_vneg;
    logic [IW-1:0]    w_bsrc;
    int               w_sh;
    logic [CHUNK-1:0] w_ca, w_cb, w_cs;
    logic             w_cin, w_cout;
    logic [IW-1:0]    w_mask, w_wval;
    logic [IW-1:0]    w_s_merge, w_c_merge;
    logic [IW-1:0]    w_sel;

    assign w_qx   = {{(IW-WIDTH){1'b0}}, i_q};
    assign w_vneg = s_q[IW-1];

    always_comb begin
        w_sh   = int'(k_q) * CHUNK;
        w_bsrc = c_q;
        w_cin  = carry_q;
        if (state_q == ST_CORRECT) begin
            w_bsrc = w_vneg ? w_qx : ~w_qx;
        end
        if (k_q == '0) begin
            w_cin = (state_q == ST_CORRECT) && !w_vneg;
        end
        w_ca = CHUNK'(s_q >> w_sh);
        w_cb = CHUNK'(w_bsrc >> w_sh);
    end

    csa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i    (w_ca),
        .b_i    (w_cb),
        .cin_i  (w_cin),
        .sum_o  (w_cs),
        .cout_o (w_cout)
    );

    assign w_mask    = IW'({CHUNK{1'b1}}) << w_sh;
    assign w_wval    = IW'(w_cs) << w_sh;
    assign w_s_merge = (s_q & ~w_mask) | (w_wval & w_mask);
    assign w_c_merge = (c_q & ~w_mask) | (w_wval & w_mask);

    // V lives in S, D in C after correction.
    assign w_sel = w_vneg ? c_q : (c_q[IW-1] ? s_q : c_q);

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        c_d      = c_q;
        k_d      = k_q;
        carry_d  = carry_q;
        valid_d  = 1'b0;
        result_d = result_q;
        err_d    = err_q;

        if (i_clr) begin
            state_d  = ST_IDLE;
            s_d      = '0;
            c_d      = '0;
            k_d      = '0;
            carry_d  = 1'b0;
            result_d = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        s_d = w_sum;
                        c_d = w_cry_sh;
                    end
                    if (i_resolve) begin
                        state_d = ST_RESOLVE;
                        k_d     = '0;
                        carry_d = 1'b0;
                    end
                end
                ST_RESOLVE: begin
                    s_d     = w_s_merge;
                    carry_d = w_cout;
                    if (k_q == K_LAST) begin
                        c_d     = '0;
                        k_d     = '0;
                        state_d = ST_CORRECT;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                ST_CORRECT: begin
                    c_d     = w_c_merge;
                    carry_d = w_cout;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Stay one extra cycle so o_ready stays low while o_valid is shown.
                    if (!valid_q) begin
                        s_d      = w_sel;
                        c_d      = '0;
                        result_d = w_sel[WIDTH-1:0];
                        err_d    = |w_sel[IW-1:WIDTH];
                        valid_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            c_q      <= c_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_err    = err_q;

endmodule : csa_mod_accum
`default_nettype wire
